// File: rtl/mem_map_pkg.sv
// Shared memory map for the processor bus: IO page select,
// one-hot IO word bits, UART status bit and UART state encoding.
package mem_map_pkg;

    localparam int IO_PAGE_BIT      = 22;
    localparam int IO_LEDS_BIT      = 0;
    localparam int IO_UART_DAT_BIT  = 1;
    localparam int IO_UART_CTRL_BIT = 2;
    localparam int UART_BUSY_BIT    = 9;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_t;

endpackage

// File: rtl/uart_tx.sv
// 8N1 serial transmitter; a start request is taken when idle or
// at the edge that ends the stop bit, so frames can run back to back.
module uart_tx
    import mem_map_pkg::*;
#(
    parameter int BAUD_DIV = 104
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       txd
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    uart_state_t   state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shreg;
    logic          tick;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= UART_IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            busy  <= 1'b0;
            txd   <= 1'b1;
        end else begin
            unique case (state)
                UART_IDLE: begin
                    if (start) begin
                        state <= UART_START;
                        shreg <= data;
                        busy  <= 1'b1;
                        txd   <= 1'b0;
                        cnt   <= '0;
                    end
                end
                UART_START: begin
                    if (tick) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= UART_DATA;
                        txd   <= shreg[0];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                UART_DATA: begin
                    if (tick) begin
                        cnt <= '0;
                        if (idx == 3'd7) begin
                            state <= UART_STOP;
                            txd   <= 1'b1;
                        end else begin
                            idx <= idx + 3'd1;
                            txd <= shreg[idx + 3'd1];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                UART_STOP: begin
                    if (tick) begin
                        cnt <= '0;
                        // back-to-back frame keeps busy high
                        if (start) begin
                            state <= UART_START;
                            shreg <= data;
                            txd   <= 1'b0;
                        end else begin
                            state <= UART_IDLE;
                            busy  <= 1'b0;
                            txd   <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Processor-side RAM plus LED/UART IO page with 1-cycle read latency.
// UART transmitter is built only when MEM_RESPONDER_UART_TX_EN is defined.
module mem_responder
    import mem_map_pkg::*;
#(
    parameter int MEM_WORDS   = 2048,
    parameter int CLK_FREQ_HZ = 12000000,
    parameter int BAUD        = 115200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic        mem_rstrb,
    output logic [31:0] mem_rdata,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wmask,
    output logic [4:0]  leds,
    output logic        uart_txd
);

    localparam int AW = $clog2(MEM_WORDS);

    logic [31:0]   ram [MEM_WORDS];
    logic [AW-1:0] word;
    logic          is_io;
    logic [2:0]    io_sel;
    logic          busy;
    logic          led_we;
    logic [31:0]   io_rdata;
    logic          unused_addr;

    assign word        = mem_addr[AW+1:2];
    assign is_io       = mem_addr[IO_PAGE_BIT];
    assign io_sel      = mem_addr[4:2];
    assign led_we      = is_io & io_sel[IO_LEDS_BIT] & mem_wmask[0];
    assign unused_addr = ^mem_addr;

    always_comb begin
        io_rdata = '0;
        if (io_sel[IO_LEDS_BIT])
            io_rdata[4:0] = leds;
        if (io_sel[IO_UART_CTRL_BIT])
            io_rdata[UART_BUSY_BIT] = busy;
    end

    // RAM has no reset so it can map onto block memory
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!is_io && mem_wmask[i])
                ram[word][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_rdata <= '0;
            leds      <= '0;
        end else begin
            if (mem_rstrb)
                mem_rdata <= is_io ? io_rdata : ram[word];
            if (led_we)
                leds <= mem_wdata[4:0];
        end
    end

`ifdef MEM_RESPONDER_UART_TX_EN
    localparam int BAUD_DIV = CLK_FREQ_HZ / BAUD;

    logic dat_we;

    assign dat_we = is_io & io_sel[IO_UART_DAT_BIT] & mem_wmask[0];

    uart_tx #(
        .BAUD_DIV(BAUD_DIV)
    ) u_uart_tx (
        .clk  (clk),
        .reset(reset),
        .start(dat_we),
        .data (mem_wdata[7:0]),
        .busy (busy),
        .txd  (uart_txd)
    );
`else
    assign busy     = 1'b0;
    assign uart_txd = 1'b1;
`endif

endmodule
